// File: rtl/led_pulse_stretch_pkg.sv
// Shared definitions for the LED pulse stretcher: state encoding and clock-rate helpers.
// Use bits_for_ms() to pick N / GAP_N for a target blink duration.
package led_pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ON      = 2'b01,
        GAP     = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam int unsigned CLK_HZ = 10_000_000;

    // Counter bits giving at least the requested duration at CLK_HZ.
    function automatic int unsigned bits_for_ms(input int unsigned ms);
        return $clog2(ms * (CLK_HZ / 1000));
    endfunction

endpackage

// File: rtl/led_pulse_stretch_timer.sv
// Loadable down-counter shared by the ON and GAP phases of the LED stretcher.
// load has priority over en; zero reflects the current count.
module pulse_dwell_timer #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/led_pulse_stretch.sv
// Stretches 1-cycle event ticks into visible LED blinks (2^N on, 2^GAP_N dark),
// queueing ticks that arrive mid-blink in a saturating pending counter.
module led_pulse_stretch
    import led_pulse_stretch_pkg::*;
#(
    parameter int unsigned N      = 19,
    parameter int unsigned GAP_N  = 19,
    parameter int unsigned PEND_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_in,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              dropped
);

    localparam int unsigned TW = (N > GAP_N) ? N : GAP_N;
    localparam logic [TW-1:0] ON_LOAD  = TW'({N{1'b1}});
    localparam logic [TW-1:0] GAP_LOAD = TW'({GAP_N{1'b1}});

    state_e            r_state;
    state_e            w_state_next;
    logic [PEND_W-1:0] r_pending;
    logic [PEND_W-1:0] w_pending_next;
    logic              r_dropped;
    logic              w_dropped_next;
    logic              w_load;
    logic [TW-1:0]     w_load_val;
    logic              w_timer_en;
    logic              w_zero;
    logic              w_inc;
    logic              w_dec;

    pulse_dwell_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_timer_en),
        .zero     (w_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = ON_LOAD;
        w_timer_en   = 1'b0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (tick_in) begin
                    w_state_next = ON;
                    w_load       = 1'b1;
                end
            end
            ON: begin
                w_timer_en = 1'b1;
                w_inc      = tick_in;
                if (w_zero) begin
                    w_state_next = GAP;
                    w_load       = 1'b1;
                    w_load_val   = GAP_LOAD;
                end
            end
            GAP: begin
                w_timer_en = 1'b1;
                w_inc      = tick_in;
                if (w_zero) begin
                    // A tick landing on the exit cycle restarts ON directly, skipping IDLE.
                    if ((r_pending != '0) || tick_in) begin
                        w_state_next = ON;
                        w_load       = 1'b1;
                        w_dec        = (r_pending != '0);
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_pending_next = r_pending;
        w_dropped_next = 1'b0;
        if (w_inc && !w_dec) begin
            if (&r_pending) begin
                w_dropped_next = 1'b1;
            end else begin
                w_pending_next = r_pending + PEND_W'(1);
            end
        end else if (w_dec && !w_inc) begin
            w_pending_next = r_pending - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_dropped <= w_dropped_next;
        end
    end

    assign led     = (r_state == ON);
    assign busy    = (r_state != IDLE);
    assign pending = r_pending;
    assign dropped = r_dropped;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed self-checking bench for led_pulse_stretch with N=3, GAP_N=2, PEND_W=2.
// Compares {led, busy, pending, dropped} each cycle against hand-derived expectations.
module tb_led_pulse_stretch;

    localparam int unsigned N      = 3;
    localparam int unsigned GAP_N  = 2;
    localparam int unsigned PEND_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick_in;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pulse_stretch #(
        .N      (N),
        .GAP_N  (GAP_N),
        .PEND_W (PEND_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_in (tick_in),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .dropped (dropped)
    );

    // Present tick for one edge, then land 1 ns into the following cycle.
    task automatic step(input logic t);
        tick_in = t;
        @(posedge clk);
        #1;
        tick_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] exp_v;
        exp_v = 5'b0;
        reset = 1'b1;
        step(1'b1);
        checks++;
        if ({led, busy, pending, dropped} !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {led, busy, pending, dropped}, exp_v);
        end
        step(1'b1);
        reset = 1'b0;
        step(1'b0);
        checks++;
        if ({led, busy, pending, dropped} !== exp_v) begin
            errors++;
            $display("FAIL reset_tick_ignored: got %b expected %b",
                     {led, busy, pending, dropped}, exp_v);
        end
    endtask

    task automatic test_single();
        logic [4:0] exp_v;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0);
        step(1'b1);
        for (int i = 1; i <= 13; i++) begin
            exp_v = {(i <= 8), (i <= 12), 2'd0, 1'b0};
            checks++;
            if ({led, busy, pending, dropped} !== exp_v) begin
                errors++;
                $display("FAIL single cyc+%0d: got %b expected %b", i,
                         {led, busy, pending, dropped}, exp_v);
            end
            step(1'b0);
        end
    endtask

    // pass 0: three queued ticks; pass 1: plus a fourth that overflows the queue.
    task automatic test_queue_overflow();
        logic [4:0] exp_v;
        int b, c, nt;
        logic [1:0] p;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            nt = (pass == 1) ? 4 : 3;
            step(1'b1);
            for (int i = 1; i <= 49; i++) begin
                b = (i - 1) / 12;
                c = (i - 1) % 12;
                p = (i < 4) ? 2'(i - 1) : 2'(3 - b);
                if (i == 49) exp_v = 5'b0;
                else exp_v = {(c < 8), 1'b1, p, (pass == 1 && i == 5)};
                checks++;
                if ({led, busy, pending, dropped} !== exp_v) begin
                    errors++;
                    $display("FAIL queue pass%0d cyc+%0d: got %b expected %b", pass, i,
                             {led, busy, pending, dropped}, exp_v);
                end
                step(i <= nt);
            end
        end
    endtask

    task automatic test_gap_exit_tick();
        logic [4:0] exp_v;
        int b, c;
        do_reset();
        step(1'b1);
        for (int i = 1; i <= 37; i++) begin
            b = (i - 1) / 12;
            c = (i - 1) % 12;
            if (i == 37) exp_v = 5'b0;
            else exp_v = {(c < 8), 1'b1, ((i >= 2 && i <= 24) ? 2'd1 : 2'd0), 1'b0};
            checks++;
            if ({led, busy, pending, dropped} !== exp_v) begin
                errors++;
                $display("FAIL gap_exit cyc+%0d (blink %0d): got %b expected %b", i, b,
                         {led, busy, pending, dropped}, exp_v);
            end
            step(i == 1 || i == 12);
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [4:0] exp_v;
        do_reset();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        exp_v = {1'b1, 1'b1, 2'd2, 1'b0};
        checks++;
        if ({led, busy, pending, dropped} !== exp_v) begin
            errors++;
            $display("FAIL midreset_pre: got %b expected %b", {led, busy, pending, dropped}, exp_v);
        end
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        exp_v = 5'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({led, busy, pending, dropped} !== exp_v) begin
                errors++;
                $display("FAIL midreset_post cyc+%0d: got %b expected %b", i,
                         {led, busy, pending, dropped}, exp_v);
            end
            step(1'b0);
        end
    endtask

    task automatic test_last_on_tick();
        logic [4:0] exp_v;
        int c;
        do_reset();
        step(1'b1);
        for (int i = 1; i <= 25; i++) begin
            c = (i - 1) % 12;
            if (i == 25) exp_v = 5'b0;
            else exp_v = {(c < 8), 1'b1, ((i >= 9 && i <= 12) ? 2'd1 : 2'd0), 1'b0};
            checks++;
            if ({led, busy, pending, dropped} !== exp_v) begin
                errors++;
                $display("FAIL last_on cyc+%0d: got %b expected %b", i,
                         {led, busy, pending, dropped}, exp_v);
            end
            step(i == 8);
        end
    endtask

    initial begin
        reset   = 1'b1;
        tick_in = 1'b0;
        #1;
        test_reset();
        test_single();
        test_queue_overflow();
        test_gap_exit_tick();
        test_reset_mid_blink();
        test_last_on_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
